nf_ahb_arbiter: RTL
===================

// Module: nf_ahb_arbiter
// PURPOSE
//  Multi-master AHB arbiter/bus mux between masters (e.g. instruction fetch, LSU, debug) and nf_ahb_router master port.
//  Grants the bus via hbusreq/hgrant handshake; muxes address/control by granted master, hwdata by data-phase owner.
//  Broadcasts hrdata/hresp/hready to all masters; holds grant across fixed-length bursts and locked sequences.
// PARAMETERS
//  master_c  2  number of masters (2..8); master 0 is the default (parked) master
// PORTS
//  hclk        in   1              AHB clock
//  hresetn     in   1              async reset, active low
//  hbusreq_m   in   master_c       bus request per master
//  hlock_m     in   master_c       locked-transfer request per master
//  hgrant_m    out  master_c       one-hot grant, registered
//  haddr_m     in   master_c x 32  master HADDR
//  hwdata_m    in   master_c x 32  master HWDATA
//  hwrite_m    in   master_c x 1   master HWRITE
//  htrans_m    in   master_c x 2   master HTRANS
//  hsize_m     in   master_c x 3   master HSIZE
//  hburst_m    in   master_c x 3   master HBURST
//  hrdata_m    out  32             hrdata broadcast to all masters
//  hresp_m     out  2              hresp broadcast
//  hready_m    out  1              hready broadcast
//  haddr/hwdata/hwrite/htrans/hsize/hburst  out  32/32/1/2/3/3  to router
//  hrdata/hresp/hready  in  32/2/1  from router
//  hmaster     out  $clog2(master_c)  address-phase owner index (== hgrant_m encoded)
//  hmastlock   out  1              hlock_m of address-phase owner, registered with grant
// BEHAVIOUR
//  Reset: hgrant_m=1 (master 0), hmaster=0, owner_d=0, beats=0, state FREE, hmastlock=0, rr_ptr=0.
//  Address mux: haddr/hwrite/htrans/hsize/hburst = master[hmaster], combinational. hwdata = hwdata_m[owner_d].
//  owner_d <= hmaster when hready=1 (data-phase owner). hrdata_m/hresp_m/hready_m = hrdata/hresp/hready.
//  Masters drive NONSEQ only when hgrant_m[i] & hready_m; parked master 0 with no request drives IDLE.
//  Beat counter (5 bit), update only when hready=1:
//   NONSEQ accepted: beats <= N-1, N=4/8/16 for INCR4|WRAP4/INCR8|WRAP8/INCR16|WRAP16; SINGLE/INCR -> 0.
//   SEQ accepted with beats>0: beats-1. IDLE/BUSY: unchanged.
//  FSM (next beats value = beats_nx):
//   FREE  : rearbitrate on hready=1; -> BURST if NONSEQ fixed burst accepted; -> LOCKED if hmastlock=1.
//   BURST : grant held; -> FREE in cycle where hready=1 and beats_nx==0 (last beat address accepted);
//           hand-over occurs in that same cycle so new owner drives address next cycle.
//   LOCKED: grant held while owner hlock_m=1; -> FREE (with rearbitration) on hready=1 & hlock_m[owner]=0.
//  Rearbitration: new grant registered only when hready=1 and state permits; else hgrant_m holds.
//   No requester -> grant parks on master 0. Owner INCR (undefined) may lose grant at any beat boundary.
//  hmastlock <= hlock_m[winner] at each grant update.
//  hready=0 (wait state): grant, beats, state, owner_d frozen regardless of requests.
//  hresp ERROR/RETRY/SPLIT: passed through; arbiter does not cancel burst (master terminates with IDLE,
//   beats forced 0 and state -> FREE when owner drives IDLE while beats>0 and hready=1).
//  Reset asserted mid-burst: all state returns to reset values asynchronously; bus shows master 0.
// CONFIGURATION
//  NF_AHB_ARB_RR_EN defined: round-robin; search starts at rr_ptr, rr_ptr <= winner+1 (mod master_c)
//   on every grant change to a requesting master.
//  Not defined: fixed priority, lowest requesting index wins; rr_ptr absent.
// TESTING
//  1 Reset, no hbusreq -> hgrant_m=0b01, hmaster=0, htrans=IDLE, hwdata follows master 0.
//  2 m1 hbusreq, single NONSEQ 0x0000_1000 write 0xCAFE -> grant m1 next ready cycle; hwdata=0xCAFE in data phase.
//  3 m1 INCR4 with m0 requesting after beat 1 -> m1 keeps grant 4 beats; m0 granted in cycle of 4th address.
//  4 Insert hready=0 for 3 cycles mid-burst -> grant/beats/owner_d unchanged; burst resumes correctly.
//  5 m1 hlock_m=1 over 2 singles, m0 requesting -> m0 waits until hlock_m[1] drops; hmastlock=1 throughout.
//  6 m0,m1 request continuously (singles): RR_EN -> grants alternate 0,1,0,1; without -> m0 always.

Source files
------------

// File: rtl/nf_ahb_arbiter.sv
// nf_ahb_arbiter: multi-master AHB arbiter and bus mux in front of the nf_ahb_router master port.
// Build option: define NF_AHB_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
//
// state     | meaning
// st_free   | no burst or lock outstanding; rearbitrate on every ready cycle
// st_burst  | fixed-length burst in flight; grant held until its last address is accepted
// st_locked | owner holds hlock; grant held until owner drops it
module nf_ahb_arbiter #(
    parameter int master_c = 2
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [master_c-1:0]          hbusreq_m,
    input  logic [master_c-1:0]          hlock_m,
    output logic [master_c-1:0]          hgrant_m,
    input  logic [master_c-1:0][31:0]    haddr_m,
    input  logic [master_c-1:0][31:0]    hwdata_m,
    input  logic [master_c-1:0]          hwrite_m,
    input  logic [master_c-1:0][1:0]     htrans_m,
    input  logic [master_c-1:0][2:0]     hsize_m,
    input  logic [master_c-1:0][2:0]     hburst_m,
    output logic [31:0]                  hrdata_m,
    output logic [1:0]                   hresp_m,
    output logic                         hready_m,
    output logic [31:0]                  haddr,
    output logic [31:0]                  hwdata,
    output logic                         hwrite,
    output logic [1:0]                   htrans,
    output logic [2:0]                   hsize,
    output logic [2:0]                   hburst,
    input  logic [31:0]                  hrdata,
    input  logic [1:0]                   hresp,
    input  logic                         hready,
    output logic [$clog2(master_c)-1:0]  hmaster,
    output logic                         hmastlock
);

    localparam int idx_w = $clog2(master_c);

    localparam logic [1:0] trans_idle   = 2'b00;
    localparam logic [1:0] trans_nonseq = 2'b10;
    localparam logic [1:0] trans_seq    = 2'b11;

    typedef enum logic [1:0] {
        st_free   = 2'd0,
        st_burst  = 2'd1,
        st_locked = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nx;
    logic [idx_w-1:0]    owner_q;
    logic [idx_w-1:0]    owner_d_q;
    logic [idx_w-1:0]    winner;
    logic [master_c-1:0] grant_q;
    logic [4:0]          beats_q;
    logic [4:0]          beats_nx;
    logic [4:0]          burst_last;
    logic                lock_q;
    logic                any_req;
    logic                rearb;
    logic                held_lock;
    logic [1:0]          cur_trans;

    assign hmaster   = owner_q;
    assign hgrant_m  = grant_q;
    assign hmastlock = lock_q;

    assign haddr     = haddr_m[owner_q];
    assign hwrite    = hwrite_m[owner_q];
    assign htrans    = htrans_m[owner_q];
    assign hsize     = hsize_m[owner_q];
    assign hburst    = hburst_m[owner_q];
    assign hwdata    = hwdata_m[owner_d_q];

    assign hrdata_m  = hrdata;
    assign hresp_m   = hresp;
    assign hready_m  = hready;

    assign cur_trans = htrans_m[owner_q];
    assign held_lock = lock_q & hlock_m[owner_q];
    assign any_req   = |hbusreq_m;

`ifdef NF_AHB_ARB_RR_EN
    logic [idx_w-1:0] rr_ptr_q;

    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < master_c; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= master_c) idx = idx - master_c;
            if (!found && hbusreq_m[idx]) begin
                winner = idx_w'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rr_ptr_q <= '0;
        end else if (hready && rearb && any_req) begin
            rr_ptr_q <= (int'(winner) == master_c - 1) ? '0 : winner + idx_w'(1);
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = master_c - 1; k >= 0; k--) begin
            if (hbusreq_m[k]) winner = idx_w'(k);
        end
    end
`endif

    // remaining-beat count loaded on NONSEQ is the burst length minus the beat being accepted
    always_comb begin
        case (hburst_m[owner_q])
            3'd2, 3'd3: burst_last = 5'd3;
            3'd4, 3'd5: burst_last = 5'd7;
            3'd6, 3'd7: burst_last = 5'd15;
            default:    burst_last = 5'd0;
        endcase
    end

    always_comb begin
        beats_nx = beats_q;
        if (hready) begin
            case (cur_trans)
                trans_nonseq: beats_nx = burst_last;
                trans_seq:    if (beats_q != 5'd0) beats_nx = beats_q - 5'd1;
                trans_idle:   beats_nx = 5'd0;
                default:      beats_nx = beats_q;
            endcase
        end
    end

    always_comb begin
        state_nx = state_q;
        rearb    = 1'b0;
        if (hready) begin
            case (state_q)
                st_free: begin
                    if (beats_nx != 5'd0) state_nx = st_burst;
                    else if (held_lock)   state_nx = st_locked;
                    else                  rearb    = 1'b1;
                end
                st_burst: begin
                    if (beats_nx == 5'd0) begin
                        if (held_lock) state_nx = st_locked;
                        else           rearb    = 1'b1;
                    end
                end
                st_locked: begin
                    if (!hlock_m[owner_q]) begin
                        if (beats_nx != 5'd0) state_nx = st_burst;
                        else                  rearb    = 1'b1;
                    end
                end
                default: rearb = 1'b1;
            endcase
            // a freshly granted locked master starts out holding the bus
            if (rearb) state_nx = hlock_m[winner] ? st_locked : st_free;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= st_free;
            owner_q   <= '0;
            grant_q   <= master_c'(1);
            owner_d_q <= '0;
            beats_q   <= 5'd0;
            lock_q    <= 1'b0;
        end else if (hready) begin
            state_q   <= state_nx;
            beats_q   <= beats_nx;
            owner_d_q <= owner_q;
            if (rearb) begin
                owner_q <= winner;
                grant_q <= master_c'(1) << winner;
                lock_q  <= hlock_m[winner];
            end
        end
    end

endmodule
